// File: rtl/bet_trit_shift_reg.sv
// Binary-encoded-ternary shift register with hold, parallel load, shift-up
// and base-3 increment. It has a sticky error flag that is set by illegal codes.
module bet_trit_shift_reg #(
  parameter int N_TRITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [2*N_TRITS-1:0]   d,
  input  logic [1:0]             sin,
  input  logic                   err_clr,
  output logic [2*N_TRITS-1:0]   q,
  output logic [1:0]             sout,
  output logic                   wrap,
  output logic                   err
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_INC   = 2'b11
  } mode_e;

  localparam logic [1:0] BET_0   = 2'b01;
  localparam logic [1:0] BET_1   = 2'b11;
  localparam logic [1:0] BET_2   = 2'b10;
  localparam logic [1:0] BET_BAD = 2'b00;

  localparam logic [2*N_TRITS-1:0] Q_ZERO = {N_TRITS{BET_0}};

  logic [2*N_TRITS-1:0] q_nxt;
  logic [1:0]           sout_nxt;
  logic                 wrap_nxt;
  logic                 err_nxt;

  logic                 d_legal;
  logic                 err_set;
  logic [2*N_TRITS+1:0] q_ext;
  logic [2*N_TRITS-1:0] q_inc;
  logic                 carry;
  logic [1:0]           trit;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    d_legal = 1'b1;
    for (int i = 0; i < N_TRITS; i++) begin
      if (d[2*i +: 2] == BET_BAD) d_legal = 1'b0;
    end

    // Shift-up is a concatenation: the low part becomes the new word,
    // and the top trit falls out into sout.
    q_ext = {q, sin};

    // Ripple carry: a trit 2 rolls over to 0 and passes the carry upward.
    carry = 1'b1;
    q_inc = q;
    for (int i = 0; i < N_TRITS; i++) begin
      trit = q[2*i +: 2];
      if (carry) begin
        unique case (trit)
          BET_0:   begin q_inc[2*i +: 2] = BET_1; carry = 1'b0; end
          BET_1:   begin q_inc[2*i +: 2] = BET_2; carry = 1'b0; end
          BET_2:   q_inc[2*i +: 2] = BET_0;
          default: begin q_inc[2*i +: 2] = BET_0; carry = 1'b0; end
        endcase
      end
    end

    q_nxt    = q;
    sout_nxt = sout;
    wrap_nxt = 1'b0;
    err_set  = 1'b0;

    unique case (mode_e'(mode))
      MODE_HOLD: ;
      MODE_LOAD: begin
        if (d_legal) q_nxt = d;
        else         err_set = 1'b1;
      end
      MODE_SHIFT: begin
        if (sin != BET_BAD) begin
          q_nxt    = q_ext[2*N_TRITS-1:0];
          sout_nxt = q_ext[2*N_TRITS+1 -: 2];
        end else begin
          err_set = 1'b1;
        end
      end
      MODE_INC: begin
        q_nxt    = q_inc;
        wrap_nxt = carry;
      end
      default: ;
    endcase

    // A new error outranks a clear in the same cycle.
    err_nxt = err_set | (err & ~err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= Q_ZERO;
      sout <= BET_0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_nxt;
      sout <= sout_nxt;
      wrap <= wrap_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bet_trit_shift_reg.sv
// Randomised and directed bench for bet_trit_shift_reg. An arithmetic base-3
// model is compared every cycle, and a second instance exercises N_TRITS=1.
module tb_bet_trit_shift_reg;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     mode;
  logic [2*N-1:0] d;
  logic [1:0]     sin;
  logic           err_clr;
  logic [2*N-1:0] q;
  logic [1:0]     sout;
  logic           wrap;
  logic           err;

  logic           rst1_n;
  logic [1:0]     mode1;
  logic [1:0]     d1;
  logic [1:0]     sin1;
  logic           err_clr1;
  logic [1:0]     q1;
  logic [1:0]     sout1;
  logic           wrap1;
  logic           err1;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bet_trit_shift_reg #(.N_TRITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .d(d), .sin(sin), .err_clr(err_clr),
    .q(q), .sout(sout), .wrap(wrap), .err(err)
  );

  bet_trit_shift_reg #(.N_TRITS(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .mode(mode1), .d(d1), .sin(sin1), .err_clr(err_clr1),
    .q(q1), .sout(sout1), .wrap(wrap1), .err(err1)
  );

  // ---------------- reference model: the word as a base-3 integer ----------------
  function automatic int pow3(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 3;
    return r;
  endfunction

  function automatic int bet2v(input logic [1:0] c);
    case (c)
      2'b01:   return 0;
      2'b11:   return 1;
      2'b10:   return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] v2bet(input int v);
    case (v)
      0:       return 2'b01;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic bit word_legal(input logic [2*N-1:0] w);
    for (int i = 0; i < N; i++) if (w[2*i +: 2] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int word_val(input logic [2*N-1:0] w);
    int v = 0;
    for (int i = 0; i < N; i++) v += bet2v(w[2*i +: 2]) * pow3(i);
    return v;
  endfunction

  function automatic logic [2*N-1:0] word_enc(input int v);
    logic [2*N-1:0] w;
    for (int i = 0; i < N; i++) w[2*i +: 2] = v2bet((v / pow3(i)) % 3);
    return w;
  endfunction

  localparam int P3N  = 81;   // 3^4
  localparam int P3N1 = 27;   // weight of the top trit

  int m_val  = 0;
  int m_sout = 0;
  bit m_wrap = 1'b0;
  bit m_err  = 1'b0;

  always @(posedge clk) begin
    bit set_err;
    set_err = 1'b0;
    if (!rst_n) begin
      m_val = 0; m_sout = 0; m_wrap = 1'b0; m_err = 1'b0;
    end else begin
      m_wrap = 1'b0;
      case (mode)
        2'b01: if (word_legal(d)) m_val = word_val(d); else set_err = 1'b1;
        2'b10: begin
          if (sin == 2'b00) set_err = 1'b1;
          else begin
            m_sout = m_val / P3N1;
            m_val  = (m_val * 3 + bet2v(sin)) % P3N;
          end
        end
        2'b11: begin
          m_val  = (m_val + 1) % P3N;
          m_wrap = (m_val == 0);
        end
        default: ;
      endcase
      if (set_err)      m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_q",    32'(q),    32'(word_enc(m_val)));
      check("model_sout", 32'(sout), 32'(v2bet(m_sout)));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
      check("model_err",  32'(err),  32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic r, input logic [1:0] m, input logic [2*N-1:0] dd,
                      input logic [1:0] s, input logic ec);
    rst_n = r; mode = m; d = dd; sin = s; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic r, input logic [1:0] m);
    rst1_n = r; mode1 = m; d1 = 2'b01; sin1 = 2'b01; err_clr1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rand_trit(input int bad_one_in);
    logic [1:0] t;
    if ($urandom_range(0, bad_one_in - 1) == 0) return 2'b00;
    t = v2bet(int'($urandom_range(0, 2)));
    return t;
  endfunction

  initial begin
    logic [2*N-1:0] rd;
    rst1_n = 1'b0; mode1 = 2'b00; d1 = 2'b01; sin1 = 2'b01; err_clr1 = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then hold for three cycles.
    step(1'b0, 2'b11, 8'h00, 2'b00, 1'b1);
    cmp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00, 8'hff, 2'b10, 1'b0);
      check("hold_q", 32'(q), 32'h55);
      check("hold_sout", 32'(sout), 32'h1);
      check("hold_wrap_err", {wrap, err}, 32'h0);
    end

    // Load trits 2,1,0,2 and then increment once.
    step(1'b1, 2'b01, 8'b10_11_01_10, 2'b01, 1'b0);
    check("load_q", 32'(q), 32'(8'b10_11_01_10));
    step(1'b1, 2'b11, 8'h00, 2'b01, 1'b0);
    check("inc_q", 32'(q), 32'(8'b10_11_11_01));
    check("inc_wrap", 32'(wrap), 32'h0);

    // Increment from all trits 2 wraps to zero.
    step(1'b1, 2'b01, 8'b10_10_10_10, 2'b01, 1'b0);
    step(1'b1, 2'b11, 8'h00, 2'b01, 1'b0);
    check("wrap_q", 32'(q), 32'h55);
    check("wrap_pulse", 32'(wrap), 32'h1);
    step(1'b1, 2'b00, 8'h00, 2'b01, 1'b0);
    check("wrap_drop", 32'(wrap), 32'h0);

    // Shift four trits in from reset, then one more.
    step(1'b0, 2'b00, 8'h00, 2'b01, 1'b0);
    step(1'b1, 2'b10, 8'h00, 2'b10, 1'b0);
    step(1'b1, 2'b10, 8'h00, 2'b11, 1'b0);
    step(1'b1, 2'b10, 8'h00, 2'b01, 1'b0);
    step(1'b1, 2'b10, 8'h00, 2'b10, 1'b0);
    check("shift4_q", 32'(q), 32'(8'b10_11_01_10));
    check("shift4_sout", 32'(sout), 32'h1);
    step(1'b1, 2'b10, 8'h00, 2'b01, 1'b0);
    check("shift5_q", 32'(q), 32'(8'b11_01_10_01));
    check("shift5_sout", 32'(sout), 32'(2'b10));

    // Illegal load sets sticky err; set beats clear; a plain clear clears it.
    step(1'b0, 2'b00, 8'h00, 2'b01, 1'b0);
    step(1'b1, 2'b01, 8'b01_01_00_01, 2'b01, 1'b0);
    check("badload_q", 32'(q), 32'h55);
    check("badload_err", 32'(err), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 8'h00, 2'b01, 1'b0);
    check("err_sticky", 32'(err), 32'h1);
    step(1'b1, 2'b10, 8'h00, 2'b00, 1'b1);
    check("set_wins_err", 32'(err), 32'h1);
    check("badshift_q", 32'(q), 32'h55);
    step(1'b1, 2'b00, 8'h00, 2'b01, 1'b1);
    check("err_cleared", 32'(err), 32'h0);

    // Single-trit instance: count through a full cycle, then reset during an increment.
    step1(1'b0, 2'b00);
    check("n1_reset_q", 32'(q1), 32'h1);
    step1(1'b1, 2'b11);
    check("n1_inc1", {q1, wrap1}, {2'b11, 1'b0});
    step1(1'b1, 2'b11);
    check("n1_inc2", {q1, wrap1}, {2'b10, 1'b0});
    step1(1'b1, 2'b11);
    check("n1_inc3", {q1, wrap1}, {2'b01, 1'b1});
    step1(1'b1, 2'b11);
    step1(1'b1, 2'b11);
    step1(1'b0, 2'b11);
    check("n1_rst_abort", {q1, wrap1}, {2'b01, 1'b0});
    step1(1'b1, 2'b11);
    check("n1_after_rst", {q1, wrap1}, {2'b11, 1'b0});
    step1(1'b1, 2'b00);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) rd[2*i +: 2] = rand_trit(12);
      step(($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)), rd,
           rand_trit(8), ($urandom_range(0, 4) == 0));
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
